// File: rtl/vga_sync_gen.sv
// VGA beam timing: position counters, sync pulses, visible flag, strobes.
// Optional frame counter: define VGA_SYNC_GEN_FRAME_COUNTER_EN.
module vga_sync_gen #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter bit          H_POL  = 1'b0,
  parameter bit          V_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       line_end,
  output logic       frame_end,
  output logic [7:0] frame
);

  localparam int unsigned H_TOTAL =
    H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL =
    V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VEND = 10'(H_VIS);
  localparam logic [9:0] V_VEND = 10'(V_VIS);
  localparam logic [9:0] H_SS = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SE =
    10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SS = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SE =
    10'(V_VIS + V_FP + V_SYNC - 1);

  logic       h_wrap;
  logic [9:0] hpos_n;
  logic [9:0] vpos_n;
  logic       hs_act;
  logic       vs_act;

  always_comb begin
    h_wrap = (hpos == H_LAST);
    hpos_n = h_wrap ? 10'd0 : hpos + 10'd1;
    vpos_n = vpos;
    if (h_wrap) begin
      vpos_n = (vpos == V_LAST) ? 10'd0
                                : vpos + 10'd1;
    end
  end

  // Decoded from next-state counters so the flops
  // line up with the position they are loaded with.
  always_comb begin
    hs_act = (hpos_n >= H_SS) && (hpos_n <= H_SE);
    vs_act = (vpos_n >= V_SS) && (vpos_n <= V_SE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos      <= 10'd0;
      vpos      <= 10'd0;
      hsync     <= ~H_POL;
      vsync     <= ~V_POL;
      visible   <= 1'b1;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else if (en) begin
      hpos      <= hpos_n;
      vpos      <= vpos_n;
      hsync     <= hs_act ? H_POL : ~H_POL;
      vsync     <= vs_act ? V_POL : ~V_POL;
      visible   <= (hpos_n < H_VEND) &&
                   (vpos_n < V_VEND);
      line_end  <= (hpos_n == H_LAST);
      frame_end <= (hpos_n == H_LAST) &&
                   (vpos_n == V_LAST);
    end
  end

`ifdef VGA_SYNC_GEN_FRAME_COUNTER_EN
  logic [7:0] frame_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= 8'd0;
    end else if (en && frame_end) begin
      frame_q <= frame_q + 8'd1;
    end
  end

  assign frame = frame_q;
`else
  assign frame = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing and tiny-timing instances,
// scoreboard model plus directed timing checks.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       vis;
    logic       le;
    logic       fe;
    logic [7:0] fr;
  } obs_t;

  typedef struct packed {
    obs_t b;
    obs_t s;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;

  logic [9:0] b_hpos, b_vpos, s_hpos, s_vpos;
  logic b_hsync, b_vsync, b_vis, b_le, b_fe;
  logic s_hsync, s_vsync, s_vis, s_le, s_fe;
  logic [7:0] b_frame, s_frame;

  exp_t sb[$];
  int total = 0;
  int passed = 0;
  int bh = 0, bv = 0, sh = 0, sv = 0;
  logic [7:0] bf = 8'd0, sf = 8'd0;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk(clk), .reset(reset), .en(en),
    .hpos(b_hpos), .vpos(b_vpos),
    .hsync(b_hsync), .vsync(b_vsync),
    .visible(b_vis), .line_end(b_le),
    .frame_end(b_fe), .frame(b_frame)
  );

  vga_sync_gen #(
    .H_VIS(2), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_VIS(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b0)
  ) dut_s (
    .clk(clk), .reset(reset), .en(en),
    .hpos(s_hpos), .vpos(s_vpos),
    .hsync(s_hsync), .vsync(s_vsync),
    .visible(s_vis), .line_end(s_le),
    .frame_end(s_fe), .frame(s_frame)
  );

  function automatic obs_t got_b();
    obs_t o;
    o = {b_hpos, b_vpos, b_hsync, b_vsync,
         b_vis, b_le, b_fe, b_frame};
    return o;
  endfunction

  function automatic obs_t got_s();
    obs_t o;
    o = {s_hpos, s_vpos, s_hsync, s_vsync,
         s_vis, s_le, s_fe, s_frame};
    return o;
  endfunction

  function automatic obs_t model(
    int h, int v, logic [7:0] f,
    int hv, int hf, int hs, int hb,
    int vv, int vf, int vs, int vb,
    bit hp, bit vp);
    obs_t o;
    o.h   = 10'(h);
    o.v   = 10'(v);
    o.hs  = (h >= hv + hf && h < hv + hf + hs)
            ? hp : !hp;
    o.vs  = (v >= vv + vf && v < vv + vf + vs)
            ? vp : !vp;
    o.vis = (h < hv) && (v < vv);
    o.le  = (h == hv + hf + hs + hb - 1);
    o.fe  = o.le && (v == vv + vf + vs + vb - 1);
    o.fr  = f;
    return o;
  endfunction

  task automatic adv(inout int h, inout int v,
                     inout logic [7:0] f,
                     input int ht, input int vt);
    if (h == ht - 1) begin
      h = 0;
      if (v == vt - 1) begin
        v = 0;
`ifdef VGA_SYNC_GEN_FRAME_COUNTER_EN
        f = f + 8'd1;
`endif
      end else begin
        v++;
      end
    end else begin
      h++;
    end
  endtask

  task automatic tick(input logic e, input logic r);
    exp_t x;
    @(negedge clk);
    en = e;
    reset = r;
    if (r) begin
      bh = 0; bv = 0; bf = 8'd0;
      sh = 0; sv = 0; sf = 8'd0;
    end else if (e) begin
      adv(bh, bv, bf, 800, 525);
      adv(sh, sv, sf, 5, 5);
    end
    x.b = model(bh, bv, bf, 640, 16, 96, 48,
                480, 10, 2, 33, 1'b0, 1'b0);
    x.s = model(sh, sv, sf, 2, 1, 1, 1,
                2, 1, 1, 1, 1'b1, 1'b0);
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    tick(1'b1, 1'b1);
    x = sb.pop_front();
    total++;
    if (got_b() !== x.b)
      $display("FAIL reset_big got %h exp %h",
               got_b(), x.b);
    else passed++;
    total++;
    if (got_s() !== x.s)
      $display("FAIL reset_small got %h exp %h",
               got_s(), x.s);
    else passed++;
    total++;
    if ({b_hsync, b_vsync, b_vis} !== 3'b111)
      $display("FAIL reset_levels got %b exp 111",
               {b_hsync, b_vsync, b_vis});
    else passed++;
    tick(1'b0, 1'b1);
    x = sb.pop_front();
    total++;
    if (got_b() !== x.b)
      $display("FAIL reset_noen got %h exp %h",
               got_b(), x.b);
    else passed++;
  endtask

  task automatic test_line();
    exp_t x;
    int hs_cnt = 0, hs_first = -1, hs_last = -1;
    int le_cnt = 0, le_pos = -1;
    logic v639 = 1'bx, v640 = 1'bx;
    logic prev_le = 1'b0, wrap_ok = 1'b0;
    for (int i = 0; i < 1601; i++) begin
      tick(1'b1, 1'b0);
      x = sb.pop_front();
      total++;
      if (got_b() !== x.b)
        $display("FAIL line_big got %h exp %h",
                 got_b(), x.b);
      else passed++;
      total++;
      if (got_s() !== x.s)
        $display("FAIL line_small got %h exp %h",
                 got_s(), x.s);
      else passed++;
      if (prev_le && b_vpos == 10'd1 &&
          b_hpos == 10'd0) wrap_ok = 1'b1;
      prev_le = 1'b0;
      if (b_vpos == 10'd0) begin
        if (b_hsync == 1'b0) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(b_hpos);
          hs_last = int'(b_hpos);
        end
        if (b_le) begin
          le_cnt++;
          le_pos = int'(b_hpos);
          prev_le = 1'b1;
        end
        if (b_hpos == 10'd639) v639 = b_vis;
        if (b_hpos == 10'd640) v640 = b_vis;
      end
    end
    total++;
    if (hs_cnt != 96)
      $display("FAIL hsync_width got %0d exp 96",
               hs_cnt);
    else passed++;
    total++;
    if (hs_first != 656 || hs_last != 751)
      $display("FAIL hsync_span got %0d..%0d exp 656..751",
               hs_first, hs_last);
    else passed++;
    total++;
    if (le_cnt != 1 || le_pos != 799)
      $display("FAIL line_end got n=%0d at %0d exp 1 at 799",
               le_cnt, le_pos);
    else passed++;
    total++;
    if (v639 !== 1'b1 || v640 !== 1'b0)
      $display("FAIL vis_edge got %b%b exp 10",
               v639, v640);
    else passed++;
    total++;
    if (!wrap_ok)
      $display("FAIL line_wrap got 0 exp 1");
    else passed++;
  endtask

  task automatic test_en_gating();
    exp_t x;
    obs_t prev, prev_s;
    int hold_err = 0;
    int h0;
    logic [9:0] v0;
    for (int i = 0; i < 900 && b_hpos != 10'd798; i++) begin
      tick(1'b1, 1'b0);
      x = sb.pop_front();
      total++;
      if (got_b() !== x.b)
        $display("FAIL seek_big got %h exp %h",
                 got_b(), x.b);
      else passed++;
    end
    total++;
    if (b_hpos !== 10'd798)
      $display("FAIL seek_798 got %0d exp 798", b_hpos);
    else passed++;
    v0 = b_vpos;
    tick(1'b1, 1'b0);
    void'(sb.pop_front());
    tick(1'b0, 1'b0);
    x = sb.pop_front();
    total++;
    if (got_b() !== x.b)
      $display("FAIL gate_hold got %h exp %h",
               got_b(), x.b);
    else passed++;
    total++;
    if ({b_le, b_hpos} !== {1'b1, 10'd799})
      $display("FAIL held_line_end got %b/%0d exp 1/799",
               b_le, b_hpos);
    else passed++;
    tick(1'b1, 1'b0);
    void'(sb.pop_front());
    total++;
    if (b_hpos !== 10'd0 || b_vpos !== v0 + 10'd1 || b_le)
      $display("FAIL gate_wrap got %0d,%0d exp 0,%0d",
               b_hpos, b_vpos, v0 + 10'd1);
    else passed++;
    h0 = int'(b_hpos);
    for (int i = 0; i < 100; i++) begin
      prev = got_b();
      prev_s = got_s();
      tick((i % 2) == 0, 1'b0);
      x = sb.pop_front();
      total++;
      if (got_b() !== x.b)
        $display("FAIL toggle_big got %h exp %h",
                 got_b(), x.b);
      else passed++;
      total++;
      if (got_s() !== x.s)
        $display("FAIL toggle_small got %h exp %h",
                 got_s(), x.s);
      else passed++;
      if ((i % 2) == 1 &&
          (got_b() !== prev || got_s() !== prev_s))
        hold_err++;
    end
    total++;
    if (hold_err != 0)
      $display("FAIL en0_hold got %0d exp 0", hold_err);
    else passed++;
    total++;
    if (b_hpos !== 10'(h0 + 50))
      $display("FAIL half_rate got %0d exp %0d",
               b_hpos, h0 + 50);
    else passed++;
  endtask

  task automatic test_reset_mid();
    exp_t x;
    for (int i = 0; i < 900 && b_hpos != 10'd300; i++) begin
      tick(1'b1, 1'b0);
      x = sb.pop_front();
      total++;
      if (got_s() !== x.s)
        $display("FAIL seek_small got %h exp %h",
                 got_s(), x.s);
      else passed++;
    end
    total++;
    if (b_hpos !== 10'd300)
      $display("FAIL seek_300 got %0d exp 300", b_hpos);
    else passed++;
    tick(1'b1, 1'b1);
    x = sb.pop_front();
    total++;
    if (got_b() !== x.b)
      $display("FAIL rmid_big got %h exp %h",
               got_b(), x.b);
    else passed++;
    total++;
    if (got_s() !== x.s)
      $display("FAIL rmid_small got %h exp %h",
               got_s(), x.s);
    else passed++;
    total++;
    if ({b_hpos, b_vpos, b_vis, b_hsync, b_vsync,
         b_le, b_fe, b_frame, s_frame} !==
        {20'd0, 5'b11100, 16'd0})
      $display("FAIL rmid_vals got %0d,%0d f=%0d/%0d",
               b_hpos, b_vpos, b_frame, s_frame);
    else passed++;
  endtask

  task automatic test_frame_wrap();
    exp_t x;
    int hs3 = 0, hs_bad = 0, vs_bad = 0;
    int fe_bad = 0, fwrap_bad = 0;
    logic prev_fe = 1'b0;
    logic [7:0] f1 = 8'hxx;
    logic [7:0] f1_exp;
`ifdef VGA_SYNC_GEN_FRAME_COUNTER_EN
    f1_exp = 8'd1;
`else
    f1_exp = 8'd0;
`endif
    for (int i = 1; i <= 6400; i++) begin
      tick(1'b1, 1'b0);
      x = sb.pop_front();
      total++;
      if (got_b() !== x.b)
        $display("FAIL fw_big got %h exp %h",
                 got_b(), x.b);
      else passed++;
      total++;
      if (got_s() !== x.s)
        $display("FAIL fw_small got %h exp %h",
                 got_s(), x.s);
      else passed++;
      if (i == 25) f1 = s_frame;
      if (s_hsync && s_hpos == 10'd3) hs3++;
      if (s_hsync && s_hpos != 10'd3) hs_bad++;
      if ((s_vsync == 1'b0) != (s_vpos == 10'd3))
        vs_bad++;
      if (s_fe != (s_hpos == 10'd4 && s_vpos == 10'd4))
        fe_bad++;
      if (prev_fe && (s_hpos != 10'd0 || s_vpos != 10'd0))
        fwrap_bad++;
      prev_fe = s_fe;
    end
    total++;
    if (f1 !== f1_exp)
      $display("FAIL frame_one got %0d exp %0d",
               f1, f1_exp);
    else passed++;
    total++;
    if (s_frame !== 8'd0 || b_frame !== 8'd0)
      $display("FAIL frame_wrap got %0d/%0d exp 0/0",
               s_frame, b_frame);
    else passed++;
    total++;
    if (hs3 != 1280 || hs_bad != 0)
      $display("FAIL small_hsync got %0d/%0d exp 1280/0",
               hs3, hs_bad);
    else passed++;
    total++;
    if (vs_bad != 0)
      $display("FAIL small_vsync got %0d exp 0", vs_bad);
    else passed++;
    total++;
    if (fe_bad != 0 || fwrap_bad != 0)
      $display("FAIL frame_end got %0d/%0d exp 0/0",
               fe_bad, fwrap_bad);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_line();
    test_en_gating();
    test_reset_mid();
    test_frame_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing generator that sits directly upstream of the top-level pixel/pattern logic in the VGA test design.
- Produces beam position (hpos, vpos), HSYNC/VSYNC, a visible-area flag and line/frame boundary strobes.
- The downstream stage forms RGB from these outputs and drives uo_out.
- All outputs come straight from flops, so the sync pins are glitch-free.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, HSYNC pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VSYNC pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, HSYNC active level (0 = active-low)
- V_POL, 0, VSYNC active level (0 = active-low)
- Derived: H_TOTAL = sum of the four H_* timing params; V_TOTAL = sum of the four V_* timing params. Both must be ≤1024 and each component ≥1.

Ports:
- clk  in  1  pixel-domain clock
- reset  in  1  synchronous, active-high reset
- en  in  1  pixel clock-enable; counters and all outputs advance only on cycles with en=1
- hpos  out  10  current pixel column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per H_POL
- vsync  out  1  vertical sync, polarity per V_POL
- visible  out  1  high when hpos<H_VIS and vpos<V_VIS
- line_end  out  1  high when hpos==H_TOTAL-1
- frame_end  out  1  high when hpos==H_TOTAL-1 and vpos==V_TOTAL-1
- frame  out  8  frame counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high, and has priority over en.
- Reset values:
  - hpos=0, vpos=0, visible=1, line_end=0, frame_end=0, frame=0
  - hsync=~H_POL, vsync=~V_POL (both inactive)
- Counters, on clk edge with en=1:
  - hpos increments; at H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos wraps from V_TOTAL-1 to 0 when hpos also wraps.
  - Counters are never reached outside their ranges.
- en=0: every register holds. Outputs stay static, so a strobe held high stays high until the next enabled cycle.
- Alignment: hsync, vsync, visible, line_end and frame_end describe the hpos/vpos value presented in the same cycle (zero latency). They are registered, so they are computed from next-state counter values.
- hsync active iff H_VIS+H_FP ≤ hpos ≤ H_VIS+H_FP+H_SYNC-1.
- vsync active iff V_VIS+V_FP ≤ vpos ≤ V_VIS+V_FP+V_SYNC-1. vsync changes at hpos wrap only, never mid-line.
- Reset mid-frame: next cycle all outputs equal their reset values, regardless of en.
- Simultaneous reset and en: reset wins.
- Width rules: comparisons are unsigned 10-bit. Parameter sums are evaluated at elaboration.

Optional Feature:
- Macro: VGA_SYNC_GEN_FRAME_COUNTER_EN.
- Defined: frame is an 8-bit register that increments on each enabled cycle where frame_end=1 (i.e. on the frame wrap). It wraps 255→0 and resets to 0.
- Not defined: frame is tied to 8'd0 and no counter flops are inferred. All other behaviour is identical.

Test Plan:
- Reset, defaults, en=1 held: after reset, hpos=0, vpos=0, visible=1, hsync=1, vsync=1. At hpos=639, visible=1; at hpos=640, visible=0.
- Line timing, defaults: hsync=0 exactly for hpos 656..751 (96 cycles). line_end=1 only at hpos=799. The next cycle gives hpos=0, vpos+1.
- Frame timing, defaults: vsync=0 for vpos 490..491 (2×800 = 1600 cycles). frame_end=1 at (799,524). The next cycle gives (0,0). A frame is 420000 enabled cycles.
- en gating: toggle en 1/0 each cycle. hpos advances once per two clocks, and all outputs are held during en=0 cycles, including a held line_end.
- Reset mid-frame: assert reset at (300,200) together with en=1. The next cycle gives (0,0), visible=1, syncs inactive, frame=0.
- Frame counter wrap, with macro defined and H=2/1/1/1, V=2/1/1/1, H_POL=1: after 256 frames (256×25 enabled cycles), frame returns to 0. Without the macro, frame stays 0 throughout. hsync=1 only at hpos=3.
